// File: rtl/xdn_pkg.sv
// Shared constants and helpers for the register file slice.
package xdn_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;

  // Smallest w with 2**w >= value; constant-foldable for parameter math.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int w = 0; w < 31; w++) begin
      if ((1 << w) < value) result = w + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/register_file_if.sv
// Control/status bundle between the register file decode and one register cell.
interface register_file_if
  import xdn_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);

  logic                  load_en;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  inc_en;
  logic                  dec_en;
  logic [DATA_WIDTH-1:0] value;
  logic                  wrap;

  modport master (
    output load_en, load_data, inc_en, dec_en,
    input  value, wrap
  );

  modport slave (
    input  load_en, load_data, inc_en, dec_en,
    output value, wrap
  );

endinterface

// File: rtl/register_cell.sv
// One register entry: parallel load, +/-1 step and registered wrap detection.
module register_cell
  import xdn_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic i_clk,
  input  logic i_srst,
  register_file_if.slave cell_if
);

  logic [DATA_WIDTH-1:0] r_value;
  logic                  r_wrap;

  // Load beats a step; simultaneous inc and dec cancel out.
  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_value <= '0;
      r_wrap  <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      if (cell_if.load_en) begin
        r_value <= cell_if.load_data;
      end else if (cell_if.inc_en && !cell_if.dec_en) begin
        r_value <= r_value + DATA_WIDTH'(1);
        r_wrap  <= &r_value;
      end else if (cell_if.dec_en && !cell_if.inc_en) begin
        r_value <= r_value - DATA_WIDTH'(1);
        r_wrap  <= ~|r_value;
      end
    end
  end

  assign cell_if.value = r_value;
  assign cell_if.wrap  = r_wrap;

endmodule

// File: rtl/register_file.sv
// CPU register file on a shared tristate bus with two ALU read ports and step logic.
// Optional macro REGISTER_FILE_ZERO_REG_EN hard-wires register 0 to zero.
module register_file
  import xdn_pkg::*;
#(
  parameter  int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter  int REG_COUNT  = 4,
  localparam int ADDR_WIDTH = clog2(REG_COUNT)
) (
  input  logic                  i_CLOCK,
  input  logic                  i_CLEAR,
  inout  wire  [DATA_WIDTH-1:0] BUS,
  input  logic                  i_READ_BUS,
  input  logic [ADDR_WIDTH-1:0] i_READ_ADDR,
  input  logic                  i_WRITE_BUS,
  input  logic [ADDR_WIDTH-1:0] i_WRITE_ADDR,
  input  logic                  i_INC,
  input  logic                  i_DEC,
  input  logic [ADDR_WIDTH-1:0] i_STEP_ADDR,
  input  logic [ADDR_WIDTH-1:0] i_A_ADDR,
  input  logic [ADDR_WIDTH-1:0] i_B_ADDR,
  output logic [DATA_WIDTH-1:0] o_A_DATA,
  output logic [DATA_WIDTH-1:0] o_B_DATA,
  output logic                  o_WRAP
);

  localparam int SLOT_COUNT = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] w_values [SLOT_COUNT];
  logic [SLOT_COUNT-1:0] w_wraps;
  logic [DATA_WIDTH-1:0] w_bus_in;
  logic                  w_step_req;

  // During a move the load source is our own driven value, not the resolved net.
  assign w_bus_in   = i_WRITE_BUS ? w_values[i_WRITE_ADDR] : BUS;
  assign w_step_req = i_INC ^ i_DEC;

  generate
    for (genvar gi = 0; gi < SLOT_COUNT; gi++) begin : g_slot
      if (gi < REG_COUNT) begin : g_cell
`ifdef REGISTER_FILE_ZERO_REG_EN
        localparam bit CELL_EN = (gi != 0);
`else
        localparam bit CELL_EN = 1'b1;
`endif
        logic w_load_hit;
        logic w_step_hit;

        register_file_if #(.DATA_WIDTH(DATA_WIDTH)) u_cell_if ();

        assign w_load_hit = CELL_EN && i_READ_BUS && (i_READ_ADDR == ADDR_WIDTH'(gi));
        assign w_step_hit = CELL_EN && w_step_req && !w_load_hit
                            && (i_STEP_ADDR == ADDR_WIDTH'(gi));

        assign u_cell_if.load_en   = w_load_hit;
        assign u_cell_if.load_data = w_bus_in;
        assign u_cell_if.inc_en    = w_step_hit && i_INC;
        assign u_cell_if.dec_en    = w_step_hit && i_DEC;

        register_cell #(.DATA_WIDTH(DATA_WIDTH)) u_cell (
          .i_clk   (i_CLOCK),
          .i_srst  (i_CLEAR),
          .cell_if (u_cell_if.slave)
        );

        assign w_values[gi] = CELL_EN ? u_cell_if.value : '0;
        assign w_wraps[gi]  = CELL_EN && u_cell_if.wrap;
      end else begin : g_hole
        assign w_values[gi] = '0;
        assign w_wraps[gi]  = 1'b0;
      end
    end
  endgenerate

  assign o_A_DATA = w_values[i_A_ADDR];
  assign o_B_DATA = w_values[i_B_ADDR];
  // Only one cell can step per cycle, so the OR is itself the registered pulse.
  assign o_WRAP   = |w_wraps;

  assign BUS = i_WRITE_BUS ? w_values[i_WRITE_ADDR] : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed vectors plus a per-cycle model compare.
module tb_register_file;

`ifdef REGISTER_FILE_ZERO_REG_EN
  localparam bit ZERO_EN = 1'b1;
`else
  localparam bit ZERO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       clear = 1'b0;
  logic       read_bus = 1'b0;
  logic       write_bus = 1'b0;
  logic       inc = 1'b0;
  logic       dec = 1'b0;
  logic [1:0] read_addr = '0;
  logic [1:0] write_addr = '0;
  logic [1:0] step_addr = '0;
  logic [1:0] a_addr = '0;
  logic [1:0] b_addr = '0;
  logic       tb_bus_en = 1'b0;
  logic [7:0] tb_bus_val = '0;
  wire  [7:0] bus;
  logic [7:0] a_data;
  logic [7:0] b_data;
  logic       wrap;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] m_regs [4];
  logic [7:0] m_next [4];
  logic       m_wrap = 1'b0;
  logic       m_next_wrap;
  logic       model_live = 1'b0;

  always #5 clk = ~clk;

  assign bus = tb_bus_en ? tb_bus_val : 8'bzzzzzzzz;

  register_file #(.DATA_WIDTH(8), .REG_COUNT(4)) dut (
    .i_CLOCK      (clk),
    .i_CLEAR      (clear),
    .BUS          (bus),
    .i_READ_BUS   (read_bus),
    .i_READ_ADDR  (read_addr),
    .i_WRITE_BUS  (write_bus),
    .i_WRITE_ADDR (write_addr),
    .i_INC        (inc),
    .i_DEC        (dec),
    .i_STEP_ADDR  (step_addr),
    .i_A_ADDR     (a_addr),
    .i_B_ADDR     (b_addr),
    .o_A_DATA     (a_data),
    .o_B_DATA     (b_data),
    .o_WRAP       (wrap)
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit writable(input logic [1:0] addr);
    return !(ZERO_EN && addr == 2'd0);
  endfunction

  function automatic logic [7:0] rd(input logic [1:0] addr);
    return writable(addr) ? m_regs[addr] : 8'h00;
  endfunction

  // Reference model: whole-file next state from the architectural rules.
  always @(posedge clk) begin
    if (clear) begin
      for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
      m_wrap     = 1'b0;
      model_live = 1'b1;
    end else if (model_live) begin
      for (int i = 0; i < 4; i++) m_next[i] = m_regs[i];
      m_next_wrap = 1'b0;
      if (read_bus && writable(read_addr))
        m_next[read_addr] = write_bus ? rd(write_addr) : tb_bus_val;
      if ((inc != dec) && writable(step_addr) && !(read_bus && read_addr == step_addr)) begin
        if (inc) begin
          m_next[step_addr] = 8'((int'(m_regs[step_addr]) + 1) % 256);
          m_next_wrap       = (m_regs[step_addr] == 8'hFF);
        end else begin
          m_next[step_addr] = 8'((int'(m_regs[step_addr]) + 255) % 256);
          m_next_wrap       = (m_regs[step_addr] == 8'h00);
        end
      end
      for (int i = 0; i < 4; i++) m_regs[i] = m_next[i];
      m_wrap = m_next_wrap;
    end
  end

  always @(negedge clk) begin
    if (model_live) begin
      chk("a_port", a_data, rd(a_addr));
      chk("b_port", b_data, rd(b_addr));
      chk("wrap", {7'b0, wrap}, {7'b0, m_wrap});
      if (write_bus) chk("bus_drive", bus, rd(write_addr));
    end
  end

  task automatic drive(input bit clr, input bit rb, input logic [1:0] ra, input logic [7:0] bv,
                       input bit wb, input logic [1:0] wa,
                       input bit in, input bit de, input logic [1:0] sa);
    clear      = clr;
    read_bus   = rb;
    read_addr  = ra;
    tb_bus_val = bv;
    tb_bus_en  = rb && !wb;
    write_bus  = wb;
    write_addr = wa;
    inc        = in;
    dec        = de;
    step_addr  = sa;
    @(posedge clk);
    #1;
    $display("cycle clr=%0b rd=%0b@%0d bus=%02h wr=%0b@%0d inc=%0b dec=%0b@%0d -> wrap=%0b",
             clr, rb, ra, bv, wb, wa, in, de, sa, wrap);
    clear = 1'b0; read_bus = 1'b0; write_bus = 1'b0; inc = 1'b0; dec = 1'b0; tb_bus_en = 1'b0;
    a_addr = a_addr + 2'd1;
    b_addr = a_addr + 2'd2;
  endtask

  task automatic load(input logic [1:0] addr, input logic [7:0] val);
    drive(0, 1, addr, val, 0, 0, 0, 0, 0);
  endtask

  task automatic peek(input string name, input logic [1:0] addr, input logic [7:0] exp);
    a_addr = addr;
    b_addr = addr;
    #1;
    chk(name, a_data, exp);
    chk(name, b_data, exp);
  endtask

  task automatic bus_lit(input string name, input logic [1:0] addr, input logic [7:0] exp);
    write_addr = addr;
    write_bus  = 1'b1;
    #1;
    chk(name, bus, exp);
    write_bus = 1'b0;
    #1;
  endtask

  task automatic wrap_lit(input string name, input bit exp);
    chk(name, {7'b0, wrap}, {7'b0, exp});
  endtask

  initial begin
    @(posedge clk);
    #1;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) peek("reset_reg", 2'(i), 8'h00);
    wrap_lit("reset_wrap", 0);

    load(2, 8'h5A);
    peek("load_r2", 2, 8'h5A);
    bus_lit("bus_r2", 2, 8'h5A);

    load(1, 8'hFF);
    drive(0, 0, 0, 0, 0, 0, 1, 0, 1);
    peek("inc_wrap_val", 1, 8'h00);
    wrap_lit("inc_wrap_pulse", 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    wrap_lit("inc_wrap_end", 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1);
    peek("dec_wrap_val", 1, 8'hFF);
    wrap_lit("dec_wrap_pulse", 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    wrap_lit("dec_wrap_end", 0);

    load(1, 8'h33);
    drive(0, 1, 3, 0, 1, 1, 0, 0, 0);
    peek("move_dst", 3, 8'h33);
    peek("move_src", 1, 8'h33);
    drive(0, 1, 2, 0, 1, 2, 0, 0, 0);
    peek("move_self", 2, 8'h5A);

    load(0, 8'hFF);
    drive(0, 1, 0, 8'h10, 0, 0, 1, 0, 0);
    peek("load_beats_step", 0, ZERO_EN ? 8'h00 : 8'h10);
    wrap_lit("load_beats_step_wrap", 0);
    load(1, 8'h07);
    drive(0, 0, 0, 0, 0, 0, 1, 1, 1);
    peek("inc_dec_cancel", 1, 8'h07);
    wrap_lit("inc_dec_wrap", 0);

    drive(0, 1, 2, 8'h42, 0, 0, 1, 0, 3);
    peek("parallel_load", 2, 8'h42);
    peek("parallel_step", 3, 8'h34);

    load(3, 8'hFF);
    drive(1, 1, 2, 8'hAA, 0, 0, 1, 0, 3);
    for (int i = 0; i < 4; i++) peek("clear_reg", 2'(i), 8'h00);
    wrap_lit("clear_wrap", 0);

    load(1, 8'hFF);
    drive(0, 0, 0, 0, 0, 0, 1, 0, 1);
    wrap_lit("pre_abort_wrap", 1);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    wrap_lit("abort_wrap", 0);

    load(0, 8'h77);
    peek("zero_reg", 0, ZERO_EN ? 8'h00 : 8'h77);
    bus_lit("zero_reg_bus", 0, ZERO_EN ? 8'h00 : 8'h77);

    for (int n = 0; n < 60; n++) begin
      drive(($urandom_range(0, 19) == 0), 1'($urandom), 2'($urandom), 8'($urandom),
            1'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 2'($urandom));
    end

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
